// File: rtl/buzzer_tone_decoder_pkg.sv
// Constants shared by the buzzer driver and the tone decoder: note half-periods,
// octave codes, decoder FSM states and the period-table entry layout.
package buzzer_tone_decoder_pkg;

  localparam logic [31:0] N_DO  = 32'd381680;
  localparam logic [31:0] N_RE  = 32'd340136;
  localparam logic [31:0] N_MI  = 32'd303030;
  localparam logic [31:0] N_FA  = 32'd285714;
  localparam logic [31:0] N_SOL = 32'd255102;
  localparam logic [31:0] N_LA  = 32'd227273;
  localparam logic [31:0] N_SI  = 32'd202429;

  localparam logic [1:0] OCT_LOW  = 2'b01;
  localparam logic [1:0] OCT_MID  = 2'b00;
  localparam logic [1:0] OCT_HIGH = 2'b10;
  localparam logic [3:0] MAX_NOTE = 4'd7;

  localparam logic [4:0] TABLE_LAST = 5'd20;

  localparam logic [1:0] ST_WAIT_EDGE = 2'd0;
  localparam logic [1:0] ST_MEASURE   = 2'd1;
  localparam logic [1:0] ST_CLASSIFY  = 2'd2;
  localparam logic [1:0] ST_UPDATE    = 2'd3;

  typedef struct packed {
    logic [31:0] nominal;
    logic [3:0]  note;
    logic [1:0]  octave;
  } tone_entry_t;

  function automatic logic [31:0] note_half_period(input logic [3:0] n);
    logic [31:0] hp;
    case (n)
      4'd1:    hp = N_DO;
      4'd2:    hp = N_RE;
      4'd3:    hp = N_MI;
      4'd4:    hp = N_FA;
      4'd5:    hp = N_SOL;
      4'd6:    hp = N_LA;
      4'd7:    hp = N_SI;
      default: hp = 32'd0;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/note_period_table.sv
// Combinational ROM of nominal half-periods: index 0..6 lower, 7..13 middle,
// 14..20 higher octave, note 1..7 within each. Out-of-range indices give note 0.
module note_period_table
  import buzzer_tone_decoder_pkg::*;
#(
  parameter int unsigned SCALE_SHIFT = 0  // shifts the whole table down; 0 for the real buzzer
) (
  input  logic [4:0]  idx,
  output tone_entry_t entry
);

  logic [4:0]  rel_s;
  logic [4:0]  num_s;
  logic [3:0]  note_s;
  logic [1:0]  oct_s;
  logic [31:0] base_s;
  logic [31:0] oct_nom_s;

  // Split the index into octave band and position within the band.
  always_comb begin
    rel_s = idx;
    oct_s = OCT_LOW;
    if (idx < 5'd7) begin
      rel_s = idx;
      oct_s = OCT_LOW;
    end else if (idx < 5'd14) begin
      rel_s = idx - 5'd7;
      oct_s = OCT_MID;
    end else begin
      rel_s = idx - 5'd14;
      oct_s = OCT_HIGH;
    end
  end

  // Look up the middle-octave period and rescale it for the band.
  always_comb begin
    num_s  = rel_s + 5'd1;
    note_s = 4'd0;
    if (num_s <= {1'b0, MAX_NOTE}) begin
      note_s = num_s[3:0];
    end else begin
      note_s = 4'd0;
    end
    base_s = note_half_period(note_s);
    case (oct_s)
      OCT_LOW:  oct_nom_s = base_s << 1;
      OCT_HIGH: oct_nom_s = base_s >> 1;
      default:  oct_nom_s = base_s;
    endcase
  end

  assign entry = '{nominal: oct_nom_s >> SCALE_SHIFT, note: note_s, octave: oct_s};

endmodule

// File: rtl/buzzer_tone_decoder.sv
// Buzzer tone receiver: measures half-periods of the speaker line, matches them
// against the note table and reports a confirmed note/octave in driver encoding.
module buzzer_tone_decoder
  import buzzer_tone_decoder_pkg::*;
#(
  parameter int unsigned MATCH_CNT   = 3,
  parameter int unsigned TOL_SHIFT   = 6,
  parameter int unsigned TIMEOUT     = 800000,
  parameter int unsigned SCALE_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tone_in,
  output logic [3:0] note,
  output logic [1:0] octave,
  output logic       valid,
  output logic       note_change
);

  localparam int unsigned    MW        = $clog2(MATCH_CNT + 1);
  localparam logic [MW-1:0]  MATCH_MAX = MW'(MATCH_CNT);
  localparam logic [31:0]    TIMEOUT_C = 32'(TIMEOUT);

  logic        sync1_r, sync2_r, prev_r;
  logic        edge_s, timeout_s;
  logic [31:0] cnt_r, meas_r, pend_meas_r, diff_s;
  logic [1:0]  state_r;
  logic        pend_r, found_r, hit_s, load_s;
  logic [4:0]  idx_r;
  logic [3:0]  cand_note_r, prev_note_r;
  logic [1:0]  cand_oct_r, prev_oct_r;
  logic [MW-1:0] match_r, match_next_s;
  tone_entry_t entry_s;

  note_period_table #(.SCALE_SHIFT(SCALE_SHIFT)) u_table (
    .idx   (idx_r),
    .entry (entry_s)
  );

  // Synchroniser keeps tracking the line through reset so release never fakes an edge.
  always_ff @(posedge clk) begin
    sync1_r <= tone_in;
    sync2_r <= sync1_r;
    prev_r  <= sync2_r;
  end

  assign edge_s    = sync2_r ^ prev_r;
  assign timeout_s = (cnt_r >= TIMEOUT_C);

  // Half-period counter: restarts at 1 on every edge, parks at the silence limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 32'd0;
    end else if (edge_s) begin
      cnt_r <= 32'd1;
    end else if (cnt_r < TIMEOUT_C) begin
      cnt_r <= cnt_r + 32'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Tolerance test without unsigned wrap: order the operands before subtracting.
  always_comb begin
    if (meas_r >= entry_s.nominal) begin
      diff_s = meas_r - entry_s.nominal;
    end else begin
      diff_s = entry_s.nominal - meas_r;
    end
    hit_s = (diff_s <= (entry_s.nominal >> TOL_SHIFT));
  end

  // Match-count update and output-load decision for the UPDATE cycle.
  always_comb begin
    match_next_s = '0;
    if (cand_note_r == 4'd0) begin
      match_next_s = '0;
    end else if ((cand_note_r == prev_note_r) && (cand_oct_r == prev_oct_r)) begin
      match_next_s = (match_r == MATCH_MAX) ? MATCH_MAX : match_r + MW'(32'd1);
    end else begin
      match_next_s = MW'(32'd1);
    end
    load_s = (match_next_s == MATCH_MAX) &&
             ((cand_note_r != note) || (cand_oct_r != octave) || !valid);
  end

  // Measurement/classification FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_WAIT_EDGE;
      meas_r      <= 32'd0;
      pend_r      <= 1'b0;
      pend_meas_r <= 32'd0;
      idx_r       <= 5'd0;
      found_r     <= 1'b0;
      cand_note_r <= 4'd0;
      cand_oct_r  <= OCT_MID;
      prev_note_r <= 4'd0;
      prev_oct_r  <= OCT_MID;
      match_r     <= '0;
      note        <= 4'd0;
      octave      <= OCT_MID;
      valid       <= 1'b0;
      note_change <= 1'b0;
    end else if (timeout_s) begin
      // An edge that ends the silence is the discarded first edge.
      state_r     <= edge_s ? ST_MEASURE : ST_WAIT_EDGE;
      pend_r      <= 1'b0;
      match_r     <= '0;
      prev_note_r <= 4'd0;
      prev_oct_r  <= OCT_MID;
      note        <= 4'd0;
      octave      <= OCT_MID;
      valid       <= 1'b0;
      note_change <= valid || (note != 4'd0);
    end else begin
      note_change <= 1'b0;
      case (state_r)
        ST_WAIT_EDGE: begin
          state_r <= edge_s ? ST_MEASURE : ST_WAIT_EDGE;
        end
        ST_MEASURE: begin
          idx_r       <= 5'd0;
          found_r     <= 1'b0;
          cand_note_r <= 4'd0;
          cand_oct_r  <= OCT_MID;
          if (pend_r) begin
            meas_r      <= pend_meas_r;
            pend_r      <= edge_s;
            pend_meas_r <= cnt_r;
            state_r     <= ST_CLASSIFY;
          end else if (edge_s) begin
            meas_r  <= cnt_r;
            state_r <= ST_CLASSIFY;
          end else begin
            state_r <= ST_MEASURE;
          end
        end
        ST_CLASSIFY: begin
          if (edge_s) begin
            pend_r      <= 1'b1;
            pend_meas_r <= cnt_r;
          end
          if (!found_r && hit_s) begin
            found_r     <= 1'b1;
            cand_note_r <= entry_s.note;
            cand_oct_r  <= entry_s.octave;
          end
          if (idx_r == TABLE_LAST) begin
            state_r <= ST_UPDATE;
          end else begin
            idx_r <= idx_r + 5'd1;
          end
        end
        ST_UPDATE: begin
          if (edge_s) begin
            pend_r      <= 1'b1;
            pend_meas_r <= cnt_r;
          end
          match_r     <= match_next_s;
          prev_note_r <= cand_note_r;
          prev_oct_r  <= cand_oct_r;
          if (load_s) begin
            note        <= cand_note_r;
            octave      <= cand_oct_r;
            valid       <= 1'b1;
            note_change <= 1'b1;
          end
          state_r <= ST_MEASURE;
        end
        default: begin
          state_r <= ST_WAIT_EDGE;
        end
      endcase
    end
  end

endmodule
